// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared definitions for the multicycle control path.
//  - opcode values of the instruction set
//  - state_t: FSM state encoding (also exported on state_dbg)
//  - mux select / ALU op encodings used by the ALU decoder and datapath
//  - ctrl_t: bundle of all control outputs produced in one cycle
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_J     = 6'b000000;
    localparam logic [5:0] OP_RTYPE = 6'b000001;
    localparam logic [5:0] OP_JAL   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b011000;
    localparam logic [5:0] OP_SUBI  = 6'b011001;
    localparam logic [5:0] OP_LW    = 6'b011010;
    localparam logic [5:0] OP_SW    = 6'b011011;
    localparam logic [5:0] OP_BEQ   = 6'b011100;
    localparam logic [5:0] OP_BNE   = 6'b011101;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_JAL    = 4'd13,
        S_FAULT  = 4'd14
    } state_t;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_SUBI  = 2'b11;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
    } ctrl_t;

    // States that hold an outstanding memory access and wait on mem_ready.
    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//  master (controller): reads op, zero, mem_ready; drives all control
//  enables/selects, fault and state_dbg.
//  slave (datapath/memory side): the mirror image.
interface multicycle_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic [5:0]         op;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               memwrite;
    logic               iord;
    logic               irwrite;
    logic               pcwrite;
    logic [1:0]         pcsrc;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [1:0]         aluop;
    logic               regwrite;
    logic [1:0]         regdst;
    logic [1:0]         memtoreg;
    logic               fault;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca,
               alusrcb, aluop, regwrite, regdst, memtoreg, fault, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca,
               alusrcb, aluop, regwrite, regdst, memtoreg, fault, state_dbg
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts consecutive cycles spent waiting on memory.
//  clk, reset (sync, active-low), en (waiting and mem_ready low),
//  clr (not waiting, or access completing), expired (this is the
//  MEM_TIMEOUT-th consecutive waiting cycle with no mem_ready).
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expired
);
    localparam int             CW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)      cnt <= '0;
        else if (clr)    cnt <= '0;
        else if (en)     cnt <= cnt + 1'b1;
    end

    // The count reaches MEM_TIMEOUT on this edge; the FSM leaves for
    // S_FAULT. A mem_ready in this same cycle drops en, so it wins.
    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multicycle 32-bit CPU.
//  clk    : clock, rising edge
//  reset  : synchronous, active-low
//  bus    : multicycle_ctrl_if.master -- op/zero/mem_ready in; memory
//           handshake, datapath selects/enables, sticky fault, state_dbg out.
// Outputs are decoded from the state register; irwrite/pcwrite in fetch
// follow mem_ready and branch pcwrite follows zero. op is taken straight
// from the instruction register, which is stable from decode onward.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);

    state_t state;
    logic   fault_q;
    logic   tmo_en, expired;
    ctrl_t  c;

    assign tmo_en = is_mem_wait(state) && !bus.mem_ready;

    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .en      (tmo_en),
        .clr     (!tmo_en),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_RESET;
            fault_q <= 1'b0;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready)  state <= S_DECODE;
                          else if (expired) begin state <= S_FAULT; fault_q <= 1'b1; end
                S_DECODE: case (bus.op)
                              OP_LW, OP_SW:     state <= S_MEMADR;
                              OP_RTYPE:         state <= S_EXEC;
                              OP_ADDI, OP_SUBI: state <= S_IEXEC;
                              OP_BEQ, OP_BNE:   state <= S_BRANCH;
                              OP_J:             state <= S_JUMP;
                              OP_JAL:           state <= S_JAL;
                              default: begin    state <= S_FAULT; fault_q <= 1'b1; end
                          endcase
                S_MEMADR: state <= (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (bus.mem_ready)  state <= S_MEMWB;
                          else if (expired) begin state <= S_FAULT; fault_q <= 1'b1; end
                S_MEMWR:  if (bus.mem_ready)  state <= S_FETCH;
                          else if (expired) begin state <= S_FAULT; fault_q <= 1'b1; end
                S_EXEC:   state <= S_ALUWB;
                S_IEXEC:  state <= S_IWB;
                S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP, S_JAL:
                          state <= S_FETCH;
                S_FAULT:  fault_q <= 1'b1;
                default: begin state <= S_FAULT; fault_q <= 1'b1; end
            endcase
        end
    end

    always_comb begin
        c = '0;
        case (state)
            S_FETCH: begin
                c.mem_req = 1'b1;
                c.irwrite = bus.mem_ready;
                c.pcwrite = bus.mem_ready;     // PC <= PC+4 as the fetch completes
                c.alusrcb = ALUB_FOUR;
                c.aluop   = ALUOP_ADD;
                c.pcsrc   = PCSRC_ALU;
            end
            S_DECODE: begin
                c.alusrcb = ALUB_IMMSH;        // precompute branch target into ALUOut
                c.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_IMM;
                c.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RT;
                c.memtoreg = MTR_MDR;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_REG;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RD;
                c.memtoreg = MTR_ALUOUT;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_IMM;
                c.aluop   = (bus.op == OP_SUBI) ? ALUOP_SUBI : ALUOP_ADD;
            end
            S_IWB: begin
                c.regwrite = 1'b1;
                c.regdst   = REGDST_RT;
                c.memtoreg = MTR_ALUOUT;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = ALUB_REG;
                c.aluop   = ALUOP_SUB;
                c.pcsrc   = PCSRC_ALUOUT;
                c.pcwrite = (bus.op == OP_BNE) ? !bus.zero : bus.zero;
            end
            S_JUMP: begin
                c.pcsrc   = PCSRC_JUMP;
                c.pcwrite = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link and the jump share a cycle.
                c.regwrite = 1'b1;
                c.regdst   = REGDST_R31;
                c.memtoreg = MTR_PC;
                c.pcsrc    = PCSRC_JUMP;
                c.pcwrite  = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign bus.mem_req   = c.mem_req;
    assign bus.memwrite  = c.memwrite;
    assign bus.iord      = c.iord;
    assign bus.irwrite   = c.irwrite;
    assign bus.pcwrite   = c.pcwrite;
    assign bus.pcsrc     = c.pcsrc;
    assign bus.alusrca   = c.alusrca;
    assign bus.alusrcb   = c.alusrcb;
    assign bus.aluop     = c.aluop;
    assign bus.regwrite  = c.regwrite;
    assign bus.regdst    = c.regdst;
    assign bus.memtoreg  = c.memtoreg;
    assign bus.fault     = fault_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed, table-driven check of the multicycle
// control FSM. Each vector drives inputs on the falling edge, checks the
// outputs 1 ns later (current state), then the rising edge advances.
module tb_multicycle_ctrl;

    localparam logic [5:0] J = 6'b000000, RT = 6'b000001, JAL = 6'b000111,
                           ADDI = 6'b011000, SUBI = 6'b011001, LW = 6'b011010,
                           SW = 6'b011011, BEQ = 6'b011100, BNE = 6'b011101,
                           ILL = 6'b111111;

    typedef struct packed {
        logic       mem_req, memwrite, iord, irwrite, pcwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb, aluop;
        logic       regwrite;
        logic [1:0] regdst, memtoreg;
        logic       fault;
        logic [3:0] st;
    } obs_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic [5:0] op;
        logic       zero;
        logic       rdy;
        obs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Expected outputs per state, written out by hand from the state table.
    function automatic obs_t x_rst();   obs_t e = '0; return e; endfunction
    function automatic obs_t x_fetch(input logic r);
        obs_t e = '0; e.st = 4'd1; e.mem_req = 1; e.irwrite = r; e.pcwrite = r;
        e.alusrcb = 2'b01; return e;
    endfunction
    function automatic obs_t x_dec();   obs_t e = '0; e.st = 4'd2; e.alusrcb = 2'b11; return e; endfunction
    function automatic obs_t x_madr();  obs_t e = '0; e.st = 4'd3; e.alusrca = 1; e.alusrcb = 2'b10; return e; endfunction
    function automatic obs_t x_mrd();   obs_t e = '0; e.st = 4'd4; e.mem_req = 1; e.iord = 1; return e; endfunction
    function automatic obs_t x_mwb();   obs_t e = '0; e.st = 4'd5; e.regwrite = 1; e.memtoreg = 2'b01; return e; endfunction
    function automatic obs_t x_mwr();   obs_t e = '0; e.st = 4'd6; e.mem_req = 1; e.memwrite = 1; e.iord = 1; return e; endfunction
    function automatic obs_t x_exec();  obs_t e = '0; e.st = 4'd7; e.alusrca = 1; e.aluop = 2'b10; return e; endfunction
    function automatic obs_t x_awb();   obs_t e = '0; e.st = 4'd8; e.regwrite = 1; e.regdst = 2'b01; return e; endfunction
    function automatic obs_t x_iexec(input logic [1:0] aop);
        obs_t e = '0; e.st = 4'd9; e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = aop; return e;
    endfunction
    function automatic obs_t x_iwb();   obs_t e = '0; e.st = 4'd10; e.regwrite = 1; return e; endfunction
    function automatic obs_t x_br(input logic pcw);
        obs_t e = '0; e.st = 4'd11; e.alusrca = 1; e.aluop = 2'b01; e.pcsrc = 2'b01;
        e.pcwrite = pcw; return e;
    endfunction
    function automatic obs_t x_jmp();   obs_t e = '0; e.st = 4'd12; e.pcsrc = 2'b10; e.pcwrite = 1; return e; endfunction
    function automatic obs_t x_jal();
        obs_t e = '0; e.st = 4'd13; e.regwrite = 1; e.regdst = 2'b10; e.memtoreg = 2'b10;
        e.pcsrc = 2'b10; e.pcwrite = 1; return e;
    endfunction
    function automatic obs_t x_flt();   obs_t e = '0; e.st = 4'd14; e.fault = 1; return e; endfunction

    function automatic obs_t get_obs();
        obs_t a;
        a.mem_req  = bus.mem_req;  a.memwrite = bus.memwrite; a.iord     = bus.iord;
        a.irwrite  = bus.irwrite;  a.pcwrite  = bus.pcwrite;  a.pcsrc    = bus.pcsrc;
        a.alusrca  = bus.alusrca;  a.alusrcb  = bus.alusrcb;  a.aluop    = bus.aluop;
        a.regwrite = bus.regwrite; a.regdst   = bus.regdst;   a.memtoreg = bus.memtoreg;
        a.fault    = bus.fault;    a.st       = bus.state_dbg;
        return a;
    endfunction

    task automatic add(input string n, input logic r_n, input logic [5:0] op,
                       input logic z, input logic rdy, input obs_t e);
        vec_t v;
        v.name = n; v.rst_n = r_n; v.op = op; v.zero = z; v.rdy = rdy; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic step(input string n, input logic r_n, input logic [5:0] op,
                        input logic z, input logic rdy, input obs_t e);
        obs_t a;
        @(negedge clk);
        reset = r_n; bus.op = op; bus.zero = z; bus.mem_ready = rdy;
        #1;
        a = get_obs();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h (state got %0d want %0d)",
                     n, a, e, a.st, e.st);
        end
    endtask

    initial begin
        reset = 1'b0; bus.op = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        add("reset_state", 1, ADDI, 0, 1, x_rst());
        // ADDI, mem_ready high throughout (ignored outside memory states)
        add("addi_fetch", 1, ADDI, 0, 1, x_fetch(1));
        add("addi_dec",   1, ADDI, 0, 1, x_dec());
        add("addi_iexec", 1, ADDI, 0, 1, x_iexec(2'b00));
        add("addi_iwb",   1, ADDI, 0, 1, x_iwb());
        add("subi_fetch", 1, SUBI, 0, 1, x_fetch(1));
        add("subi_dec",   1, SUBI, 0, 1, x_dec());
        add("subi_iexec", 1, SUBI, 0, 1, x_iexec(2'b11));
        add("subi_iwb",   1, SUBI, 0, 1, x_iwb());
        add("rt_fetch",   1, RT,   0, 1, x_fetch(1));
        add("rt_dec",     1, RT,   0, 1, x_dec());
        add("rt_exec",    1, RT,   0, 1, x_exec());
        add("rt_aluwb",   1, RT,   0, 1, x_awb());
        // LW with 3 wait cycles in fetch and in the read
        for (int i = 0; i < 3; i++) add("lw_fetch_wait", 1, LW, 0, 0, x_fetch(0));
        add("lw_fetch_done", 1, LW, 0, 1, x_fetch(1));
        add("lw_dec",        1, LW, 0, 0, x_dec());
        add("lw_madr",       1, LW, 0, 0, x_madr());
        for (int i = 0; i < 3; i++) add("lw_memrd_wait", 1, LW, 0, 0, x_mrd());
        add("lw_memrd_done", 1, LW, 0, 1, x_mrd());
        add("lw_memwb",      1, LW, 0, 0, x_mwb());
        add("sw_fetch",      1, SW, 0, 1, x_fetch(1));
        add("sw_dec",        1, SW, 0, 1, x_dec());
        add("sw_madr",       1, SW, 0, 0, x_madr());
        add("sw_memwr_wait", 1, SW, 0, 0, x_mwr());
        add("sw_memwr_done", 1, SW, 0, 1, x_mwr());
        // branches: all four zero/opcode combinations
        add("beq1_fetch", 1, BEQ, 1, 1, x_fetch(1));
        add("beq1_dec",   1, BEQ, 1, 0, x_dec());
        add("beq1_br",    1, BEQ, 1, 0, x_br(1));
        add("beq0_fetch", 1, BEQ, 0, 1, x_fetch(1));
        add("beq0_dec",   1, BEQ, 0, 0, x_dec());
        add("beq0_br",    1, BEQ, 0, 0, x_br(0));
        add("bne1_fetch", 1, BNE, 1, 1, x_fetch(1));
        add("bne1_dec",   1, BNE, 1, 0, x_dec());
        add("bne1_br",    1, BNE, 1, 0, x_br(0));
        add("bne0_fetch", 1, BNE, 0, 1, x_fetch(1));
        add("bne0_dec",   1, BNE, 0, 0, x_dec());
        add("bne0_br",    1, BNE, 0, 0, x_br(1));
        add("j_fetch",    1, J,   0, 1, x_fetch(1));
        add("j_dec",      1, J,   0, 0, x_dec());
        add("j_jump",     1, J,   0, 0, x_jmp());
        add("jal_fetch",  1, JAL, 0, 1, x_fetch(1));
        add("jal_dec",    1, JAL, 0, 0, x_dec());
        add("jal_jal",    1, JAL, 0, 0, x_jal());
        add("jal_back",   1, JAL, 0, 0, x_fetch(0));
        add("jal_back2",  1, ILL, 0, 1, x_fetch(1));
        // illegal opcode: fault is sticky, mem_ready ignored
        add("ill_dec",    1, ILL, 0, 0, x_dec());
        add("ill_fault",  1, ILL, 0, 1, x_flt());
        add("ill_sticky", 1, ILL, 0, 1, x_flt());
        add("ill_rst",    0, ILL, 0, 0, x_flt());
        add("ill_clear",  1, LW,  0, 1, x_rst());
        // reset held two cycles in the middle of a read
        add("rmid_fetch", 1, LW, 0, 1, x_fetch(1));
        add("rmid_dec",   1, LW, 0, 0, x_dec());
        add("rmid_madr",  1, LW, 0, 0, x_madr());
        add("rmid_memrd", 0, LW, 0, 0, x_mrd());
        add("rmid_rst2",  0, LW, 0, 1, x_rst());
        add("rmid_rel",   1, LW, 0, 0, x_rst());

        foreach (vq[i]) step(vq[i].name, vq[i].rst_n, vq[i].op, vq[i].zero, vq[i].rdy, vq[i].exp);

        // mem_ready arriving on the 15th waiting cycle still completes the fetch
        for (int i = 0; i < 14; i++) step("tmo_edge_wait", 1, J, 0, 0, x_fetch(0));
        step("tmo_edge_ready", 1, J, 0, 1, x_fetch(1));
        step("tmo_edge_dec",   1, J, 0, 0, x_dec());
        step("tmo_edge_jump",  1, J, 0, 0, x_jmp());

        // 15 cycles with mem_ready stuck low in fetch -> fault
        for (int i = 0; i < 15; i++) step("tmo_wait", 1, J, 0, 0, x_fetch(0));
        step("tmo_fault",  1, J, 0, 0, x_flt());
        step("tmo_sticky", 1, J, 0, 1, x_flt());
        step("tmo_rst",    0, J, 0, 0, x_flt());
        step("tmo_clear",  1, J, 0, 0, x_rst());
        step("tmo_refetch",1, J, 0, 0, x_fetch(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
